// File: rtl/branch_pc_unit_if.sv
// Decode/ALU-facing bundle of branch_pc_unit: control, operands, flags and PC-side results.
interface branch_pc_unit_if #(
  parameter int WORD = 64
);
  logic            stall;
  logic            halt;
  logic [2:0]      branch_type;
  logic [3:0]      cond;
  logic [WORD-1:0] branch_offset;
  logic [WORD-1:0] br_target;
  logic            set_flags;
  logic            alu_zero;
  logic            alu_negative;
  logic            alu_carry;
  logic            alu_overflow;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] pc_plus4;
  logic            link_we;
  logic            branch_taken;
  logic [3:0]      nzcv;
  logic            halted;
  logic            fault;

  modport master (
    output stall, halt, branch_type, cond, branch_offset, br_target, set_flags,
           alu_zero, alu_negative, alu_carry, alu_overflow,
    input  pc, pc_plus4, link_we, branch_taken, nzcv, halted, fault
  );

  modport slave (
    input  stall, halt, branch_type, cond, branch_offset, br_target, set_flags,
           alu_zero, alu_negative, alu_carry, alu_overflow,
    output pc, pc_plus4, link_we, branch_taken, nzcv, halted, fault
  );
endinterface

// File: rtl/branch_pc_unit.sv
// PC and NZCV register for the LEGv8 core: resolves branches and selects the next fetch address.
module branch_pc_unit #(
  parameter int              WORD     = 64,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  branch_pc_unit_if.slave bus
);
  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;
  typedef enum logic [2:0] {
    BT_NONE, BT_B, BT_BL, BT_CBZ, BT_CBNZ, BT_BCOND, BT_BR
  } btype_t;

  state_t          state_q;
  logic [WORD-1:0] pc_q, pc_d;
  logic [3:0]      nzcv_q, nzcv_d;
  logic            run, retire, cond_true, taken, br_misaligned;
  logic [WORD-1:0] pc_plus4, rel_target;

  assign run           = (state_q == ST_RUN);
  assign retire        = run && !bus.stall;
  assign pc_plus4      = pc_q + WORD'(4);
  assign rel_target    = pc_q + (bus.branch_offset << 2);
  assign br_misaligned = (bus.branch_type == BT_BR) && (bus.br_target[1:0] != 2'b00);

  // Odd codes invert the even base condition, except 0xF which is also "always".
  always_comb begin
    cond_true = 1'b1;
    case (bus.cond[3:1])
      3'd0: cond_true = nzcv_q[2];
      3'd1: cond_true = nzcv_q[1];
      3'd2: cond_true = nzcv_q[3];
      3'd3: cond_true = nzcv_q[0];
      3'd4: cond_true = nzcv_q[1] & ~nzcv_q[2];
      3'd5: cond_true = (nzcv_q[3] == nzcv_q[0]);
      3'd6: cond_true = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
      default: cond_true = 1'b1;
    endcase
    if (bus.cond[0] && (bus.cond[3:1] != 3'd7)) cond_true = ~cond_true;
  end

  always_comb begin
    taken = 1'b0;
    case (bus.branch_type)
      BT_B, BT_BL, BT_BR: taken = 1'b1;
      BT_CBZ:             taken = bus.alu_zero;
      BT_CBNZ:            taken = ~bus.alu_zero;
      BT_BCOND:           taken = cond_true;
      default:            taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    nzcv_d = nzcv_q;
    if (retire) begin
      if (bus.set_flags)
        nzcv_d = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
      if (!bus.halt && !br_misaligned) begin
        if (!taken)                          pc_d = pc_plus4;
        else if (bus.branch_type == BT_BR)   pc_d = bus.br_target;
        else                                 pc_d = rel_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      nzcv_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      nzcv_q <= nzcv_d;
      if (retire) begin
        if (bus.halt)           state_q <= ST_HALT;
        else if (br_misaligned) state_q <= ST_FAULT;
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.nzcv         = nzcv_q;
  assign bus.branch_taken = run && taken;
  assign bus.link_we      = retire && (bus.branch_type == BT_BL);
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.fault        = (state_q == ST_FAULT);
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with RESET_PC = 0x1000.
module tb_branch_pc_unit;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M4 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.WORD(64)) bus ();
  branch_pc_unit #(.WORD(64), .RESET_PC(64'h1000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        rst, stall, halt;
    logic [2:0]  bt;
    logic [3:0]  cond;
    logic [63:0] off, brt;
    logic        sf;
    logic [3:0]  fl;
    logic        chk, e_bt, e_lw;
    logic [63:0] e_pc;
    logic [3:0]  e_nzcv;
    logic        e_h, e_f;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] prev_pc;

  function automatic vec_t mk(logic rst, logic stall, logic halt, logic [2:0] bt,
                              logic [3:0] cond, logic [63:0] off, logic [63:0] brt,
                              logic sf, logic [3:0] fl, logic chk, logic e_bt, logic e_lw,
                              logic [63:0] e_pc, logic [3:0] e_nzcv, logic e_h, logic e_f);
    vec_t v;
    v.rst = rst; v.stall = stall; v.halt = halt; v.bt = bt; v.cond = cond;
    v.off = off; v.brt = brt; v.sf = sf; v.fl = fl; v.chk = chk;
    v.e_bt = e_bt; v.e_lw = e_lw; v.e_pc = e_pc; v.e_nzcv = e_nzcv; v.e_h = e_h; v.e_f = e_f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    bus.stall          = v.stall;
    bus.halt           = v.halt;
    bus.branch_type    = v.bt;
    bus.cond           = v.cond;
    bus.branch_offset  = v.off;
    bus.br_target      = v.brt;
    bus.set_flags      = v.sf;
    bus.alu_negative   = v.fl[3];
    bus.alu_zero       = v.fl[2];
    bus.alu_carry      = v.fl[1];
    bus.alu_overflow   = v.fl[0];
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    if (v.chk) begin
      chk($sformatf("v%0d branch_taken", idx), 64'(bus.branch_taken), 64'(v.e_bt));
      chk($sformatf("v%0d link_we", idx), 64'(bus.link_we), 64'(v.e_lw));
      chk($sformatf("v%0d pc_plus4", idx), bus.pc_plus4, prev_pc + 64'd4);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pc", idx), bus.pc, v.e_pc);
    chk($sformatf("v%0d nzcv", idx), 64'(bus.nzcv), 64'(v.e_nzcv));
    chk($sformatf("v%0d halted", idx), 64'(bus.halted), 64'(v.e_h));
    chk($sformatf("v%0d fault", idx), 64'(bus.fault), 64'(v.e_f));
    prev_pc = v.e_pc;
  endtask

  initial begin
    prev_pc = '0;
    drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));

    //         rst st ha bt cond off  brt        sf fl   chk bt lw  pc        nzcv h f
    vq.push_back(mk(1,0,0,0,4'h0,0,   0,         0,4'h0, 0,0,0, 64'h1000,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         0,4'h0, 1,0,0, 64'h1004,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         0,4'h0, 1,0,0, 64'h1008,4'h0,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         0,4'h0, 1,0,0, 64'h100C,4'h0,0,0));
    vq.push_back(mk(0,0,0,6,4'h0,0,   64'h2000,  0,4'h0, 1,1,0, 64'h2000,4'h0,0,0));
    vq.push_back(mk(0,0,0,1,4'h0,M4,  0,         0,4'h0, 1,1,0, 64'h1FF0,4'h0,0,0));
    vq.push_back(mk(0,0,0,2,4'h0,8,   0,         0,4'h0, 1,1,1, 64'h2010,4'h0,0,0));
    vq.push_back(mk(0,0,0,5,4'hB,4,   0,         1,4'h8, 1,0,0, 64'h2014,4'h8,0,0));
    vq.push_back(mk(0,0,0,5,4'hB,4,   0,         0,4'h0, 1,1,0, 64'h2024,4'h8,0,0));
    vq.push_back(mk(0,0,0,5,4'hA,4,   0,         0,4'h0, 1,0,0, 64'h2028,4'h8,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         1,4'h2, 1,0,0, 64'h202C,4'h2,0,0));
    vq.push_back(mk(0,0,0,5,4'h8,2,   0,         0,4'h0, 1,1,0, 64'h2034,4'h2,0,0));
    vq.push_back(mk(0,0,0,5,4'h9,2,   0,         0,4'h0, 1,0,0, 64'h2038,4'h2,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         1,4'h6, 1,0,0, 64'h203C,4'h6,0,0));
    vq.push_back(mk(0,0,0,5,4'h8,2,   0,         0,4'h0, 1,0,0, 64'h2040,4'h6,0,0));
    vq.push_back(mk(0,0,0,5,4'h9,2,   0,         0,4'h0, 1,1,0, 64'h2048,4'h6,0,0));
    vq.push_back(mk(0,0,0,5,4'hA,2,   0,         0,4'h0, 1,1,0, 64'h2050,4'h6,0,0));
    vq.push_back(mk(0,0,0,5,4'h0,M2,  0,         0,4'h0, 1,1,0, 64'h2048,4'h6,0,0));
    vq.push_back(mk(0,0,0,3,4'h0,4,   0,         0,4'h4, 1,1,0, 64'h2058,4'h6,0,0));
    vq.push_back(mk(0,0,0,4,4'h0,4,   0,         0,4'h0, 1,1,0, 64'h2068,4'h6,0,0));
    vq.push_back(mk(0,0,0,3,4'h0,4,   0,         0,4'h0, 1,0,0, 64'h206C,4'h6,0,0));
    vq.push_back(mk(0,1,0,2,4'h0,8,   0,         1,4'hF, 1,1,0, 64'h206C,4'h6,0,0));
    vq.push_back(mk(0,1,0,2,4'h0,8,   0,         1,4'hF, 1,1,0, 64'h206C,4'h6,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         0,4'h0, 1,0,0, 64'h2070,4'h6,0,0));
    vq.push_back(mk(0,0,0,6,4'h0,0,   64'h3002,  0,4'h0, 1,1,0, 64'h2070,4'h6,0,1));
    vq.push_back(mk(0,0,0,1,4'h0,4,   0,         1,4'hF, 1,0,0, 64'h2070,4'h6,0,1));
    vq.push_back(mk(0,0,0,2,4'h0,8,   0,         0,4'h0, 1,0,0, 64'h2070,4'h6,0,1));
    vq.push_back(mk(1,1,0,2,4'h0,8,   0,         1,4'hF, 0,0,0, 64'h1000,4'h0,0,0));
    vq.push_back(mk(0,0,0,6,4'h0,0,   M4,        0,4'h0, 1,1,0, M4,      4'h0,0,0));
    vq.push_back(mk(0,0,0,0,4'h0,0,   0,         0,4'h0, 1,0,0, 64'h0,   4'h0,0,0));
    vq.push_back(mk(0,0,0,1,4'h0,M2,  0,         0,4'h0, 1,1,0, M8,      4'h0,0,0));
    vq.push_back(mk(0,0,1,1,4'h0,4,   0,         1,4'h9, 0,0,0, M8,      4'h9,1,0));
    vq.push_back(mk(0,0,0,1,4'h0,4,   0,         0,4'h0, 1,0,0, M8,      4'h9,1,0));
    vq.push_back(mk(0,0,1,2,4'h0,8,   0,         1,4'h0, 1,0,0, M8,      4'h9,1,0));
    vq.push_back(mk(1,0,0,0,4'h0,0,   0,         0,4'h0, 0,0,0, 64'h1000,4'h0,0,0));
    vq.push_back(mk(0,1,1,0,4'h0,0,   0,         1,4'hF, 1,0,0, 64'h1000,4'h0,0,0));
    vq.push_back(mk(0,0,0,7,4'h0,4,   0,         0,4'h0, 1,0,0, 64'h1004,4'h0,0,0));
    vq.push_back(mk(0,0,0,5,4'hF,4,   0,         0,4'h0, 1,1,0, 64'h1014,4'h0,0,0));

    foreach (vq[i]) apply(vq[i], i);

    // Three stalled edges with flag-setting BL pending, then a clean release.
    apply(mk(0,0,0,0,4'h0,0,0, 1,4'hA, 1,0,0, 64'h1018,4'hA,0,0), 100);
    for (int unsigned k = 0; k < 3; k++)
      apply(mk(0,1,0,2,4'h0,8,0, 1,4'h5, 1,1,0, 64'h1018,4'hA,0,0), 101 + int'(k));
    apply(mk(0,0,0,5,4'hB,4,0, 0,4'h0, 1,1,0, 64'h1028,4'hA,0,0), 104);

    // Halt outranks a misaligned BR in the same retiring cycle.
    apply(mk(0,0,1,6,4'h0,0,64'h3002, 0,4'h0, 1,1,0, 64'h1028,4'hA,1,0), 105);
    apply(mk(1,0,0,0,4'h0,0,0, 0,4'h0, 0,0,0, 64'h1000,4'h0,0,0), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
